knn_top2_stream: RTL and testbench
==================================

Name: knn_top2_stream

Overview:
- Parametrised streaming successor to the fixed 8-candidate nearest-pair sorter.
- Accepts one query vector per frame and a variable-length stream of up to MAX_CAND candidate vectors, one per beat.
- Returns the indices and distances of the two nearest candidates, using L1 distance over unsigned elements.
- Sits between the candidate fetch stage and the result writer. Valid/ready handshake on both sides.

Parameters:
- ELEM_W, 8: bits per unsigned vector element.
- NUM_ELEM, 8: elements per vector; vector width VEC_W = ELEM_W*NUM_ELEM.
- MAX_CAND, 16: maximum candidates per frame; IDX_W = clog2(MAX_CAND).
- DIST_W, ELEM_W+clog2(NUM_ELEM): distance width; default 11.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  candidate beat valid.
- in_ready  out  1  block can accept a beat.
- in_first  in  1  first beat of frame; query sampled on this beat.
- in_last  in  1  last beat of frame.
- query  in  VEC_W  query vector, sampled only on an accepted first beat.
- cand  in  VEC_W  candidate vector; its index is its beat position in the frame, starting at 0.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- addr_1st  out  IDX_W  index of the nearest candidate.
- addr_2nd  out  IDX_W  index of the second-nearest candidate.
- dist_1st  out  DIST_W  distance of addr_1st.
- dist_2nd  out  DIST_W  distance of addr_2nd.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset: in_ready=1 and all other outputs 0. Frame state, index counter and pipeline valids are cleared asynchronously. Reset mid-frame discards the frame and any pending result.
- Accept: a beat is accepted when in_valid && in_ready.
- Distance: L1 = sum over elements of |q_e - c_e|, computed at full width with no saturation. Maximum value is NUM_ELEM*(2^ELEM_W-1).
- Pipeline:
  - S1 registers the per-element absolute differences, with index, valid and last.
  - S2 registers the adder-tree sum.
  - S3 updates the running best-two registers.
  - Throughput is one beat per cycle within a frame.
- Latency: out_valid rises 3 cycles after the cycle in which the last beat is accepted.
- Ranking and ties:
  - A new distance replaces best1 only if strictly less than it; the old best1 then shifts to best2.
  - Otherwise it replaces best2 only if strictly less than best2.
  - Equal distances therefore keep the lower index ahead.
  - Running registers initialise to dist = all-ones, idx = 0 on the first beat of each frame.
- Single-candidate frame: addr_2nd=addr_1st and dist_2nd=all-ones.
- Frame FSM has three states:
  - IDLE: an accepted beat with in_first → RUN. An accepted beat without in_first is dropped and sets err.
  - RUN: index increments per accepted beat.
    - An accepted beat with in_last, or the beat with index MAX_CAND-1 (forced last), → DRAIN and drops in_ready.
    - The forced-last case sets err if in_last was not asserted.
    - in_first during RUN restarts the frame: the query is re-latched, the index resets to 0 and err is set.
  - DRAIN: in_ready=0 until the result is loaded into the output register and then accepted (out_valid && out_ready) → IDLE, with in_ready=1 on the next cycle.
- Output hold: the output register is held stable while out_valid && !out_ready.
- Frame gap: the minimum gap between frames is 4 cycles with out_ready tied high.
- in_first && in_last on the same beat is a legal 1-candidate frame.

Optional Feature:
- Macro DIST_L2_EN.
- Defined:
  - Distance is squared Euclidean: the sum of (q_e - c_e)^2.
  - Stage S1 registers the squares.
  - The caller must set DIST_W = 2*ELEM_W + clog2(NUM_ELEM), which is 19 at defaults.
  - Ranking, handshake and latency are unchanged.
- Undefined: L1 as specified above.

Test Plan:
- Frame, 8 candidates: query=0; candidate bytes all equal to {9,3,7,1,5,2,8,4}, i.e. cand i has every byte = that value.
  - Response: addr_1st=3, dist_1st=8; addr_2nd=5, dist_2nd=16.
  - out_valid is high exactly 3 cycles after the last accept.
- Tie: 4 candidates, all with distance 40 → addr_1st=0, addr_2nd=1.
- Backpressure: out_ready held 0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - Release → out_valid drops the next cycle and in_ready rises.
- Single-beat frame (in_first && in_last), query=0x01..01, cand=0 → addr_1st=addr_2nd=0, dist_1st=8, dist_2nd=0x7FF.
- Protocol errors:
  - Beat without in_first in IDLE → dropped and err=1.
  - 16 beats without in_last → forced last, result emitted, err=1.
  - Assert rst_n=0 mid-frame → err=0, out_valid=0, in_ready=1.
- DIST_L2_EN build: query=0, cand bytes {3,2} → addr_1st=1, dist_1st=32; addr_2nd=0, dist_2nd=72.

Source files
------------

// File: rtl/knn_top2_stream.sv
// Streaming two-nearest-neighbour finder: one query per frame, up to MAX_CAND candidates.
// Build option: define DIST_L2_EN for squared-Euclidean distance instead of L1.
module knn_top2_stream #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 8,
  parameter int MAX_CAND = 16,
  localparam int VEC_W   = ELEM_W * NUM_ELEM,
  localparam int IDX_W   = $clog2(MAX_CAND),
`ifdef DIST_L2_EN
  parameter int DIST_W   = 2 * ELEM_W + $clog2(NUM_ELEM)
`else
  parameter int DIST_W   = ELEM_W + $clog2(NUM_ELEM)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [VEC_W-1:0]  query,
  input  logic [VEC_W-1:0]  cand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  addr_1st,
  output logic [IDX_W-1:0]  addr_2nd,
  output logic [DIST_W-1:0] dist_1st,
  output logic [DIST_W-1:0] dist_2nd,
  output logic              err,
  output logic [1:0]        dbg_state
);

`ifdef DIST_L2_EN
  localparam int TERM_W = 2 * ELEM_W;
`else
  localparam int TERM_W = ELEM_W;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds its payload stable while valid && !ready.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  cnt;
  logic [VEC_W-1:0]  query_r;
  logic              take, beat_first, beat_last, forced, err_set;
  logic [IDX_W-1:0]  beat_idx;
  logic [VEC_W-1:0]  q_use;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready   = (state != ST_DRAIN);
    take       = 1'b0;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    beat_idx   = cnt;
    forced     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_first) begin
            take       = 1'b1;
            beat_first = 1'b1;
            beat_idx   = '0;
            beat_last  = in_last;
            state_n    = in_last ? ST_DRAIN : ST_RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          take       = 1'b1;
          beat_first = in_first;
          beat_idx   = in_first ? '0 : cnt;
          forced     = (beat_idx == IDX_W'(MAX_CAND - 1));
          beat_last  = in_last || forced;
          err_set    = in_first || (forced && !in_last);
          if (beat_last) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      query_r <= '0;
      err     <= 1'b0;
    end else begin
      if (take) begin
        cnt <= beat_idx + IDX_W'(1);
        if (beat_first) query_r <= query;
      end
      if (err_set) err <= 1'b1;
    end
  end

  // The first beat carries its own query, so it bypasses the latch.
  assign q_use = beat_first ? query : query_r;

  logic [ELEM_W-1:0] ad     [NUM_ELEM];
  logic [TERM_W-1:0] term_n [NUM_ELEM];
  logic [TERM_W-1:0] s1_term[NUM_ELEM];
  logic              s1_valid, s1_first, s1_last;
  logic [IDX_W-1:0]  s1_idx;

  always_comb begin
    for (int e = 0; e < NUM_ELEM; e++) begin
      if (q_use[e*ELEM_W +: ELEM_W] >= cand[e*ELEM_W +: ELEM_W])
        ad[e] = q_use[e*ELEM_W +: ELEM_W] - cand[e*ELEM_W +: ELEM_W];
      else
        ad[e] = cand[e*ELEM_W +: ELEM_W] - q_use[e*ELEM_W +: ELEM_W];
`ifdef DIST_L2_EN
      term_n[e] = TERM_W'(ad[e]) * TERM_W'(ad[e]);
`else
      term_n[e] = ad[e];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      for (int e = 0; e < NUM_ELEM; e++) s1_term[e] <= '0;
    end else begin
      s1_valid <= take;
      s1_first <= beat_first;
      s1_last  <= beat_last;
      s1_idx   <= beat_idx;
      if (take) begin
        for (int e = 0; e < NUM_ELEM; e++) s1_term[e] <= term_n[e];
      end
    end
  end

  logic [DIST_W-1:0] sum_n;
  logic [DIST_W-1:0] s2_dist;
  logic              s2_valid, s2_first, s2_last;
  logic [IDX_W-1:0]  s2_idx;

  always_comb begin
    sum_n = '0;
    for (int e = 0; e < NUM_ELEM; e++) sum_n = sum_n + DIST_W'(s1_term[e]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_idx   <= '0;
      s2_dist  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_idx   <= s1_idx;
      if (s1_valid) s2_dist <= sum_n;
    end
  end

  logic [DIST_W-1:0] best1_d, best2_d, base1_d, base2_d, new1_d, new2_d;
  logic [IDX_W-1:0]  best1_i, best2_i, base1_i, base2_i, new1_i, new2_i;

  // Strict less-than keeps the earlier (lower) index ahead on equal distances.
  always_comb begin
    base1_d = s2_first ? '1 : best1_d;
    base1_i = s2_first ? '0 : best1_i;
    base2_d = s2_first ? '1 : best2_d;
    base2_i = s2_first ? '0 : best2_i;
    new1_d  = base1_d;
    new1_i  = base1_i;
    new2_d  = base2_d;
    new2_i  = base2_i;
    if (s2_dist < base1_d) begin
      new2_d = base1_d;
      new2_i = base1_i;
      new1_d = s2_dist;
      new1_i = s2_idx;
    end else if (s2_dist < base2_d) begin
      new2_d = s2_dist;
      new2_i = s2_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best1_d <= '1;
      best1_i <= '0;
      best2_d <= '1;
      best2_i <= '0;
    end else if (s2_valid) begin
      best1_d <= new1_d;
      best1_i <= new1_i;
      best2_d <= new2_d;
      best2_i <= new2_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      addr_1st  <= '0;
      addr_2nd  <= '0;
      dist_1st  <= '0;
      dist_2nd  <= '0;
    end else if (s2_valid && s2_last) begin
      out_valid <= 1'b1;
      addr_1st  <= new1_i;
      addr_2nd  <= new2_i;
      dist_1st  <= new1_d;
      dist_2nd  <= new2_d;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_knn_top2_stream.sv
// Directed bench for knn_top2_stream with a result scoreboard and reference distance model.
// Build with DIST_L2_EN defined to exercise the squared-Euclidean variant.
module tb_knn_top2_stream;

`ifdef DIST_L2_EN
  localparam int DW = 19;
`else
  localparam int DW = 11;
`endif
  localparam int RES_W = 8 + 2 * DW;
  localparam logic [DW-1:0] D_ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic          in_ready;
  logic [63:0]   query = '0, cand = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    addr_1st, addr_2nd;
  logic [DW-1:0] dist_1st, dist_2nd;
  logic          err;
  logic [1:0]    dbg_state;

  logic [RES_W-1:0] exp_q[$];
  logic [63:0]      cand_a[16];
  int               n_pass = 0, n_total = 0;

  knn_top2_stream #(.ELEM_W(8), .NUM_ELEM(8), .MAX_CAND(16), .DIST_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .query(query), .cand(cand),
    .out_valid(out_valid), .out_ready(out_ready), .addr_1st(addr_1st),
    .addr_2nd(addr_2nd), .dist_1st(dist_1st), .dist_2nd(dist_2nd),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic int dist_f(input logic [63:0] q, input logic [63:0] c);
    int s, a, b, d;
    s = 0;
    for (int e = 0; e < 8; e++) begin
      a = int'(q[e*8 +: 8]);
      b = int'(c[e*8 +: 8]);
      d = (a > b) ? a - b : b - a;
`ifdef DIST_L2_EN
      s += d * d;
`else
      s += d;
`endif
    end
    return s;
  endfunction

  // Reference: argmin with lowest index, then argmin over the remaining candidates.
  task automatic push_model(input logic [63:0] q, input int n);
    int d[16];
    int i1, i2;
    logic [DW-1:0] d2;
    for (int i = 0; i < n; i++) d[i] = dist_f(q, cand_a[i]);
    i1 = 0;
    for (int i = 1; i < n; i++) if (d[i] < d[i1]) i1 = i;
    if (n == 1) begin
      i2 = i1;
      d2 = D_ONES;
    end else begin
      i2 = -1;
      for (int i = 0; i < n; i++)
        if (i != i1 && (i2 < 0 || d[i] < d[i2])) i2 = i;
      d2 = DW'(d[i2]);
    end
    exp_q.push_back({4'(i1), 4'(i2), DW'(d[i1]), d2});
  endtask

  task automatic drive_beat(input logic f, input logic l, input logic [63:0] q, input logic [63:0] c);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l; query = q; cand = c;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("beat_accept", guard < 64, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  // Non-first beats carry a corrupted query so a missing latch shows up.
  task automatic send_frame(input logic [63:0] q, input int n, input logic use_last);
    for (int i = 0; i < n; i++)
      drive_beat(i == 0, use_last && (i == n - 1), (i == 0) ? q : ~q, cand_a[i]);
    push_model(q, n);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic compare_head(input string tag);
    logic [RES_W-1:0] r;
    chk({tag, "_qsize"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      r = exp_q[0];
      chk({tag, "_addr_1st"}, addr_1st, r[RES_W-1 -: 4]);
      chk({tag, "_addr_2nd"}, addr_2nd, r[RES_W-5 -: 4]);
      chk({tag, "_dist_1st"}, dist_1st, r[2*DW-1 -: DW]);
      chk({tag, "_dist_2nd"}, dist_2nd, r[DW-1:0]);
    end
  endtask

  task automatic score(input string tag);
    compare_head(tag);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_ir_rise"}, in_ready, 1);
  endtask

  initial begin
    int cyc, n;
    logic [63:0] q;
    logic [7:0] vals[8];

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_addr_1st", addr_1st, 0);
    chk("rst_addr_2nd", addr_2nd, 0);
    chk("rst_dist_1st", dist_1st, 0);
    chk("rst_dist_2nd", dist_2nd, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-candidate frame with latency check
    vals = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd2, 8'd8, 8'd4};
    for (int i = 0; i < 8; i++) cand_a[i] = rep(vals[i]);
    send_frame(64'd0, 8, 1'b1);
    wait_out(cyc);
    chk("f8_latency", cyc, 3);
    score("f8");
    chk("f8_addr_1st_const", addr_1st, 3);
    chk("f8_addr_2nd_const", addr_2nd, 5);
    chk("f8_dist_1st_const", dist_1st, 8);
`ifdef DIST_L2_EN
    chk("f8_dist_2nd_const", dist_2nd, 32);
`else
    chk("f8_dist_2nd_const", dist_2nd, 16);
`endif
    consume("f8");
    chk("f8_err", err, 0);

    // Tie: all four candidates equidistant
    for (int i = 0; i < 4; i++) cand_a[i] = rep(8'd5);
    send_frame(64'd0, 4, 1'b1);
    wait_out(cyc);
    score("tie");
    chk("tie_addr_1st_const", addr_1st, 0);
    chk("tie_addr_2nd_const", addr_2nd, 1);
`ifndef DIST_L2_EN
    chk("tie_dist_const", dist_1st, 40);
`endif
    consume("tie");

    // Two candidates {3,2}
    cand_a[0] = rep(8'd3);
    cand_a[1] = rep(8'd2);
    send_frame(64'd0, 2, 1'b1);
    wait_out(cyc);
    score("two");
`ifdef DIST_L2_EN
    chk("l2_addr_1st", addr_1st, 1);
    chk("l2_dist_1st", dist_1st, 32);
    chk("l2_addr_2nd", addr_2nd, 0);
    chk("l2_dist_2nd", dist_2nd, 72);
`endif
    consume("two");

    // Random frames
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(2, 15);
      q = {$urandom, $urandom};
      for (int i = 0; i < n; i++) cand_a[i] = {$urandom, $urandom};
      send_frame(q, n, 1'b1);
      wait_out(cyc);
      chk("rnd_latency", cyc, 3);
      score("rnd");
      consume("rnd");
    end

    // Backpressure: hold result for 10 cycles
    out_ready = 1'b0;
    q = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) cand_a[i] = {$urandom, $urandom};
    send_frame(q, 6, 1'b1);
    wait_out(cyc);
    for (int k = 0; k < 10; k++) begin
      compare_head("hold");
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    score("bp");
    out_ready = 1'b1;
    consume("bp");

    // Single-beat frame
    cand_a[0] = 64'd0;
    send_frame(rep(8'd1), 1, 1'b1);
    wait_out(cyc);
    score("one");
    chk("one_addr_1st_const", addr_1st, 0);
    chk("one_addr_2nd_const", addr_2nd, 0);
    chk("one_dist_1st_const", dist_1st, 8);
    chk("one_dist_2nd_const", dist_2nd, D_ONES);
    consume("one");
    chk("one_err", err, 0);

    // Stray beat in IDLE is dropped and flags err
    drive_beat(1'b0, 1'b0, 64'd0, rep(8'd7));
    repeat (6) @(negedge clk);
    chk("stray_no_out", out_valid, 0);
    chk("stray_err", err, 1);

    // 16 beats without in_last: forced last
    q = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) cand_a[i] = {$urandom, $urandom};
    send_frame(q, 16, 1'b0);
    wait_out(cyc);
    chk("forced_latency", cyc, 3);
    score("forced");
    consume("forced");
    chk("forced_err", err, 1);

    // Reset mid-frame discards everything
    drive_beat(1'b1, 1'b0, 64'd0, rep(8'd1));
    drive_beat(1'b0, 1'b1, 64'd0, rep(8'd2));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_err", err, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_no_out", out_valid, 0);

    // in_first mid-frame restarts the frame
    drive_beat(1'b1, 1'b0, rep(8'd50), rep(8'd50));
    drive_beat(1'b0, 1'b0, rep(8'd50), rep(8'd51));
    drive_beat(1'b0, 1'b0, rep(8'd50), rep(8'd52));
    q = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) cand_a[i] = {$urandom, $urandom};
    send_frame(q, 3, 1'b1);
    wait_out(cyc);
    score("restart");
    consume("restart");
    chk("restart_err", err, 1);
    chk("final_qsize", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
